// File: rtl/uart_genome_dumper.sv
// Transmit side of the genome UART link: serialises the active core configuration
// as a 42-byte .gnm frame (8N1, LSB first) that a genome loader can ingest unchanged.
module uart_genome_dumper #(
  parameter int          CLK_FREQ  = 27000000,
  parameter int          BAUD_RATE = 115200,
  parameter logic [7:0]  VERSION   = 8'h11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  poly_freq_in,
  input  logic [255:0] dna_in,
  input  logic         otp_en,
  output logic         uart_tx,
  output logic         tx_busy,
  output logic         frame_done
);

  localparam int         CLK_DIV   = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [5:0]  LAST_BYTE = 6'd41;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]   state_r;
  logic [15:0]  baud_cnt_r;
  logic [2:0]   bit_idx_r;
  logic [5:0]   byte_idx_r;
  logic [31:0]  freq_r;
  logic [255:0] dna_r;
  logic         otp_r;
  logic         baud_end_s;
  logic [7:0]   cur_byte_s;

  // Byte k of the frame; DNA is redacted to zero under the burn-on-read policy.
  function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic [31:0] freq,
                                            input logic [255:0] dna, input logic otp);
    logic [8:0] off;
    off = {idx - 6'd10, 3'b000};
    case (idx)
      6'd0:    frame_byte = 8'h41;
      6'd1:    frame_byte = 8'h54;
      6'd2:    frame_byte = 8'h4F;
      6'd3:    frame_byte = 8'h4D;
      6'd4:    frame_byte = VERSION;
      6'd5:    frame_byte = freq[7:0];
      6'd6:    frame_byte = freq[15:8];
      6'd7:    frame_byte = freq[23:16];
      6'd8:    frame_byte = freq[31:24];
      6'd9:    frame_byte = {7'b0000000, otp};
      default: begin
        if ((idx > LAST_BYTE) || otp) frame_byte = 8'h00;
        else                          frame_byte = dna[off +: 8];
      end
    endcase
  endfunction

  assign baud_end_s = (baud_cnt_r >= BAUD_LAST);
  assign cur_byte_s = frame_byte(byte_idx_r, freq_r, dna_r, otp_r);

  // Frame sequencer: bit timing, byte stepping and registered line/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= 16'd0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 6'd0;
      freq_r     <= 32'd0;
      dna_r      <= 256'd0;
      otp_r      <= 1'b0;
      uart_tx    <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            freq_r     <= poly_freq_in;
            dna_r      <= dna_in;
            otp_r      <= otp_en;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 6'd0;
            uart_tx    <= 1'b0;
            tx_busy    <= 1'b1;
            state_r    <= S_START;
          end else begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
          end
        end
        S_START: begin
          if (baud_end_s) begin
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            uart_tx    <= cur_byte_s[0];
            state_r    <= S_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_end_s) begin
            baud_cnt_r <= 16'd0;
            if (bit_idx_r == 3'd7) begin
              uart_tx <= 1'b1;
              state_r <= S_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              uart_tx   <= cur_byte_s[bit_idx_r + 3'd1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        S_STOP: begin
          if (baud_end_s) begin
            baud_cnt_r <= 16'd0;
            if (byte_idx_r == LAST_BYTE) begin
              uart_tx    <= 1'b1;
              tx_busy    <= 1'b0;
              frame_done <= 1'b1;
              state_r    <= S_DONE;
            end else begin
              byte_idx_r <= byte_idx_r + 6'd1;
              uart_tx    <= 1'b0;
              state_r    <= S_START;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        S_DONE: begin
          frame_done <= 1'b0;
          tx_busy    <= 1'b0;
          uart_tx    <= 1'b1;
          state_r    <= S_IDLE;
        end
        default: begin
          frame_done <= 1'b0;
          tx_busy    <= 1'b0;
          uart_tx    <= 1'b1;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_genome_dumper.sv
// Directed bench for uart_genome_dumper at CLK_DIV=10: decodes the serial line
// and checks frame content, redaction, snapshot/ignore behaviour, timing and abort.
module tb_uart_genome_dumper;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  poly_freq_in;
  logic [255:0] dna_in;
  logic         otp_en;
  logic         uart_tx;
  logic         tx_busy;
  logic         frame_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cyc = 0;
  logic [255:0] dna_pat;
  logic [7:0]   exp_a [42];
  logic [7:0]   exp_b [42];

  uart_genome_dumper #(.CLK_FREQ(1000), .BAUD_RATE(100), .VERSION(8'h11)) dut (
    .clk(clk), .rst(rst), .start(start), .poly_freq_in(poly_freq_in), .dna_in(dna_in),
    .otp_en(otp_en), .uart_tx(uart_tx), .tx_busy(tx_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Counts frame_done pulses, sampled away from the active edge.
  always @(negedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a start bit, samples mid-bit, checks data and stop bit.
  task automatic rx_byte(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    logic       stop_bit;
    bit         seen;
    seen = 1'b0;
    b = 8'h00;
    stop_bit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (uart_tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_start"}, 32'(seen), 32'd1);
    if (seen) begin
      repeat (4) tick();
      for (int j = 0; j < 8; j++) begin
        repeat (10) tick();
        b[j] = uart_tx;
      end
      repeat (10) tick();
      stop_bit = uart_tx;
    end
    chk(tag, 32'({stop_bit, b}), 32'({1'b1, exp}));
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_done_latency"}, 32'(cyc - acc_cyc), 32'd4200);
    chk({tag, "_done_busy_tx"}, 32'({tx_busy, uart_tx}), 32'b01);
  endtask

  task automatic accept(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    acc_cyc = cyc;
    chk({tag, "_accept"}, 32'({tx_busy, uart_tx}), 32'b10);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dna_pat[i*8 +: 8] = 8'(i + 1);
    exp_a[0] = 8'h41; exp_a[1] = 8'h54; exp_a[2] = 8'h4F; exp_a[3] = 8'h4D;
    exp_a[4] = 8'h11; exp_a[5] = 8'h78; exp_a[6] = 8'h56; exp_a[7] = 8'h34;
    exp_a[8] = 8'h12; exp_a[9] = 8'h00;
    for (int k = 10; k < 42; k++) exp_a[k] = 8'(k - 9);
    for (int k = 0; k < 42; k++) exp_b[k] = (k < 10) ? exp_a[k] : 8'h00;
    exp_b[9] = 8'h01;

    rst = 1'b1;
    start = 1'b0;
    otp_en = 1'b0;
    poly_freq_in = 32'h12345678;
    dna_in = dna_pat;
    repeat (3) tick();
    chk("reset_outputs", 32'({uart_tx, tx_busy, frame_done}), 32'b100);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk($sformatf("idle_%0d", i), 32'({uart_tx, tx_busy, frame_done}), 32'b100);
    end

    // Frame 1: plain dump, with an ignored start and a dna_in change mid-frame.
    accept("f1");
    for (int k = 0; k < 42; k++) begin
      rx_byte($sformatf("f1_b%0d", k), exp_a[k]);
      if (k == 20) begin
        start = 1'b1;
        dna_in = '1;
        tick();
        start = 1'b0;
        chk("f1_restart_ignored", 32'(tx_busy), 32'd1);
      end
    end
    wait_done("f1");

    // Start in the done cycle is ignored; held into the next idle cycle it is accepted.
    start = 1'b1;
    otp_en = 1'b1;
    dna_in = dna_pat;
    tick();
    chk("done_cycle_start_ignored", 32'({tx_busy, uart_tx, frame_done}), 32'b010);
    tick();
    start = 1'b0;
    acc_cyc = cyc;
    chk("f2_accept", 32'({tx_busy, uart_tx}), 32'b10);
    chk("f1_done_count", 32'(done_cnt), 32'd1);
    for (int k = 0; k < 42; k++) rx_byte($sformatf("f2_b%0d", k), exp_b[k]);
    wait_done("f2");
    tick();
    chk("f2_done_count", 32'(done_cnt), 32'd2);

    // Frame 3: reset at byte 7, bit 3 (0x34 bit 3 is 0 on the line).
    otp_en = 1'b0;
    repeat (5) tick();
    accept("f3");
    repeat (745) tick();
    chk("f3_byte7_bit3", 32'({tx_busy, uart_tx}), 32'b10);
    rst = 1'b1;
    tick();
    chk("f3_abort", 32'({uart_tx, tx_busy, frame_done}), 32'b100);
    rst = 1'b0;
    begin
      bit quiet;
      quiet = 1'b1;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (!(uart_tx === 1'b1 && tx_busy === 1'b0 && frame_done === 1'b0)) quiet = 1'b0;
      end
      chk("f3_quiet_after_abort", 32'(quiet), 32'd1);
    end
    chk("f3_no_done", 32'(done_cnt), 32'd2);

    // Frame 4: clean resume from byte 0.
    accept("f4");
    for (int k = 0; k < 42; k++) rx_byte($sformatf("f4_b%0d", k), exp_a[k]);
    wait_done("f4");
    tick();
    chk("f4_done_count", 32'(done_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
